// File: rtl/ddfs_multi_if.sv
// Configuration handshake bundle for ddfs_multi: one {channel, frequency word, phase}
// update per valid/ready transfer.
interface ddfs_multi_if #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 20,
    parameter int N        = 8
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [ACC_W-1:0] cfg_fw;
    logic [N-1:0]     cfg_phase;

    modport master (output cfg_valid, cfg_ch, cfg_fw, cfg_phase, input cfg_ready);
    modport slave  (input cfg_valid, cfg_ch, cfg_fw, cfg_phase, output cfg_ready);
endinterface

// File: rtl/ddfs_multi.sv
// Multi-channel DDFS with quarter-wave sine table and wrap-synchronised retuning.
// Optional macro DDFS_SWEEP_EN adds a saturating linear frequency sweep on channel 0.
//
// state   | meaning
// S_EMPTY | no pending config; cfg_ready high outside reset
// S_PEND  | config held until target channel wraps (or target fw is 0)
module ddfs_multi #(
    parameter int CHANNELS = 2,
    parameter int ACC_W    = 20,
    parameter int N        = 8,
    parameter int M        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
`ifdef DDFS_SWEEP_EN
    input  logic                  sweep_en,
    input  logic [ACC_W-1:0]      sweep_step,
`endif
    ddfs_multi_if.slave           cfg,
    output logic [CHANNELS*M-1:0] sine,
    output logic [CHANNELS-1:0]   wrap
);
    localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int Q    = 2 ** (N - 2);
    localparam logic [M-1:0] HALF = {1'b1, {(M-1){1'b0}}};

    typedef enum logic {S_EMPTY, S_PEND} slot_e;

    function automatic int qval(int i);
        real amp;
        real ang;
        amp = real'(2 ** (M - 1) - 1);
        ang = 2.0 * 3.14159265358979 * (real'(i) + 0.5) / real'(2 ** N);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

    logic [M-1:0] qtab [Q];
    for (genvar i = 0; i < Q; i++) begin : g_qtab
        localparam logic [M-1:0] QV = M'(qval(i));
        assign qtab[i] = QV;
    end

    slot_e            state_q, state_d;
    logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
    logic [ACC_W-1:0] pend_fw_q, pend_fw_d;
    logic [N-1:0]     pend_ph_q, pend_ph_d;
    logic [ACC_W-1:0] acc_q [CHANNELS];
    logic [ACC_W-1:0] acc_d [CHANNELS];
    logic [ACC_W-1:0] fw_q  [CHANNELS];
    logic [ACC_W-1:0] fw_d  [CHANNELS];
    logic [N-1:0]     ph_q  [CHANNELS];
    logic [N-1:0]     ph_d  [CHANNELS];
    logic [N-1:0]     addr_q [CHANNELS];
    logic [N-1:0]     addr_d [CHANNELS];
    logic [M-1:0]     sine_q [CHANNELS];
    logic [M-1:0]     sine_d [CHANNELS];
    logic [M-1:0]     look   [CHANNELS];
    logic [CHANNELS-1:0] wrap_q, wrap_d;
    logic [CHANNELS-1:0] fresh_wrap;
    logic             en_q;
    logic             ch_ok;
    logic             applied;

    // wrap_q holds while en=0, so only a wrap produced by a real advance may trigger retuning
    assign fresh_wrap    = wrap_q & {CHANNELS{en_q}};
    assign ch_ok         = (int'(pend_ch_q) < CHANNELS);
    assign cfg.cfg_ready = (state_q == S_EMPTY) && !rst;
    assign wrap          = wrap_q;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [N-3:0] idx;
        logic [M-1:0] mag;
        assign idx  = addr_q[c][N-2] ? ~addr_q[c][N-3:0] : addr_q[c][N-3:0];
        assign mag  = qtab[idx];
        assign look[c] = addr_q[c][N-1] ? (HALF - mag) : (HALF + mag);
        assign sine[c*M +: M] = sine_q[c];
    end

`ifdef DDFS_SWEEP_EN
    logic [ACC_W:0] sweep_sum;
    assign sweep_sum = {1'b0, fw_q[0]} + {1'b0, sweep_step};
`endif

    always_comb begin
        state_d   = state_q;
        pend_ch_d = pend_ch_q;
        pend_fw_d = pend_fw_q;
        pend_ph_d = pend_ph_q;
        acc_d     = acc_q;
        fw_d      = fw_q;
        ph_d      = ph_q;
        addr_d    = addr_q;
        sine_d    = sine_q;
        wrap_d    = wrap_q;
        applied   = 1'b0;

`ifdef DDFS_SWEEP_EN
        if (sweep_en && fresh_wrap[0]) begin
            fw_d[0] = sweep_sum[ACC_W] ? '1 : sweep_sum[ACC_W-1:0];
        end
`endif

        for (int c = 0; c < CHANNELS; c++) begin
            if (en) begin
                {wrap_d[c], acc_d[c]} = {1'b0, acc_q[c]} + {1'b0, fw_q[c]};
                addr_d[c] = acc_q[c][ACC_W-1 -: N] + ph_q[c];
                sine_d[c] = look[c];
            end
            // pending update overrides the sweep on the same wrap
            if (state_q == S_PEND && ch_ok && pend_ch_q == CH_W'(c) &&
                (fresh_wrap[c] || fw_q[c] == '0)) begin
                fw_d[c] = pend_fw_q;
                ph_d[c] = pend_ph_q;
                applied = 1'b1;
            end
        end

        case (state_q)
            S_EMPTY: begin
                if (cfg.cfg_valid) begin
                    state_d   = S_PEND;
                    pend_ch_d = cfg.cfg_ch;
                    pend_fw_d = cfg.cfg_fw;
                    pend_ph_d = cfg.cfg_phase;
                end
            end
            S_PEND: begin
                if (!ch_ok || applied) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_EMPTY;
            pend_ch_q <= '0;
            pend_fw_q <= '0;
            pend_ph_q <= '0;
            wrap_q    <= '0;
            en_q      <= 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                acc_q[c]  <= '0;
                fw_q[c]   <= '0;
                ph_q[c]   <= '0;
                addr_q[c] <= '0;
                sine_q[c] <= HALF;
            end
        end else begin
            state_q   <= state_d;
            pend_ch_q <= pend_ch_d;
            pend_fw_q <= pend_fw_d;
            pend_ph_q <= pend_ph_d;
            wrap_q    <= wrap_d;
            en_q      <= en;
            acc_q     <= acc_d;
            fw_q      <= fw_d;
            ph_q      <= ph_d;
            addr_q    <= addr_d;
            sine_q    <= sine_d;
        end
    end
endmodule
